// File: rtl/demux_burst_sched.sv
// Round-robin burst scheduler that time-shares one bit-serial stream among four consumers
// by steering a downstream 1-to-4 demultiplexer.
module demux_burst_sched #(
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned TIMEOUT   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic       in_data,
    output logic       in_ready,
    input  logic [3:0] dst_ready,
    output logic       s1,
    output logic       s0,
    output logic       out_en,
    output logic       out_data,
    output logic [3:0] out_valid,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] last_grant_q, last_grant_d;
    logic [7:0] burst_cnt_q, burst_cnt_d;
    logic [7:0] stall_cnt_q, stall_cnt_d;
    logic       timeout_err_q, timeout_err_d;

    logic [1:0] winner;
    logic [1:0] cand;
    logic       found;
    logic       transfer;

    // Search starts just after the previous grant so every ready consumer gets a turn.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cand = last_grant_q + 2'(i);
            if (!found && dst_ready[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign transfer = in_valid & dst_ready[sel_q];

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        last_grant_d  = last_grant_q;
        burst_cnt_d   = burst_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        timeout_err_d = 1'b0;
        in_ready      = 1'b0;
        out_valid     = 4'b0000;
        out_en        = 1'b0;
        busy          = 1'b0;
        out_data      = 1'b0;
        case (state_q)
            StIdle: begin
                if (found) begin
                    sel_d       = winner;
                    state_d     = StBurst;
                    burst_cnt_d = '0;
                    stall_cnt_d = '0;
                end
            end
            StBurst: begin
                out_en           = 1'b1;
                busy             = 1'b1;
                in_ready         = dst_ready[sel_q];
                out_data         = in_data;
                out_valid[sel_q] = transfer;
                if (transfer) begin
                    stall_cnt_d = '0;
                    if (burst_cnt_q == 8'(BURST_LEN - 1)) begin
                        state_d      = StIdle;
                        last_grant_d = sel_q;
                        burst_cnt_d  = '0;
                    end else begin
                        burst_cnt_d = burst_cnt_q + 8'd1;
                    end
                end else if (in_valid) begin
                    // Only a waiting source counts as a stall; an idle source keeps the grant.
                    if (stall_cnt_q == 8'(TIMEOUT - 1)) begin
                        state_d       = StIdle;
                        last_grant_d  = sel_q;
                        timeout_err_d = 1'b1;
                    end else begin
                        stall_cnt_d = stall_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            sel_q         <= 2'd0;
            last_grant_q  <= 2'd3;
            burst_cnt_q   <= '0;
            stall_cnt_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            last_grant_q  <= last_grant_d;
            burst_cnt_q   <= burst_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign s1          = sel_q[1];
    assign s0          = sel_q[0];
    assign timeout_err = timeout_err_q;

endmodule
